dsp_pipe_skid_reg: RTL and testbench

- Pipeline register stage for the DSP slice datapath with a full valid/ready handshake on both sides.
- Upstream writes beats in; downstream reads them out and may stall.
- A two-entry skid buffer absorbs one beat of backpressure, so s_ready is fully registered with no combinational path from m_ready.
- Sits between DSP pipeline stages (A/B/C/D operand paths, P output) wherever a consumer can stall.

---
 rtl/dsp_pipe_skid_reg.sv | 141 ++++++++++++++
 tb/tb_dsp_pipe_skid_reg.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_pipe_skid_reg.sv
// dsp_pipe_skid_reg: two-entry valid/ready pipeline register for DSP operand and result paths.
// Latency: a beat accepted on one rising edge is presented on m_valid/m_data right after that edge.
// Backpressure: a skid entry absorbs one stalled beat; s_ready is decoded from state only, never from m_ready.
module dsp_pipe_skid_reg #(
   parameter int WIDTH = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [1:0]       count
);

   // Occupancy state: main register holds the oldest beat, skid holds the second.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] main;
   logic [WIDTH-1:0] skid;

   logic             in_xfer;
   logic             out_xfer;
   logic             load_main_in;
   logic             load_main_skid;
   logic             load_skid;

   // Handshakes complete only when both sides agree; s_ready/m_valid are state decodes.
   assign in_xfer  = s_valid & s_ready;
   assign out_xfer = m_valid & m_ready;

   // State register; reset empties the stage immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and data-load selection; flush wins over any handshake in the same cycle.
   always_comb begin
      state_nxt      = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (in_xfer) begin
                  state_nxt    = ONE;
                  load_main_in = 1'b1;
               end
            end
            ONE: begin
               if (in_xfer && out_xfer) begin
                  // Oldest beat leaves while the new one takes its place.
                  load_main_in = 1'b1;
               end else if (in_xfer) begin
                  // Consumer stalled: park the new beat behind the main register.
                  state_nxt = TWO;
                  load_skid = 1'b1;
               end else if (out_xfer) begin
                  state_nxt = EMPTY;
               end
            end
            TWO: begin
               // s_ready is low here, so only a drain can happen.
               if (out_xfer) begin
                  state_nxt      = ONE;
                  load_main_skid = 1'b1;
               end
            end
            default: begin
               state_nxt = EMPTY;
            end
         endcase
      end
   end

   // Output decode of the state register only, keeping both handshake outputs free of input paths.
   always_comb begin
      s_ready = 1'b1;
      m_valid = 1'b0;
      count   = 2'd0;
      case (state)
         EMPTY: begin
            s_ready = 1'b1;
            m_valid = 1'b0;
            count   = 2'd0;
         end
         ONE: begin
            s_ready = 1'b1;
            m_valid = 1'b1;
            count   = 2'd1;
         end
         TWO: begin
            s_ready = 1'b0;
            m_valid = 1'b1;
            count   = 2'd2;
         end
         default: begin
            s_ready = 1'b1;
            m_valid = 1'b0;
            count   = 2'd0;
         end
      endcase
   end

   // Data registers; flush leaves them untouched since m_valid already masks stale contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main <= '0;
         skid <= '0;
      end else begin
         if (load_main_in) begin
            main <= s_data;
         end else if (load_main_skid) begin
            main <= skid;
         end
         if (load_skid) begin
            skid <= s_data;
         end
      end
   end

   assign m_data = main;

endmodule

// File: tb/tb_dsp_pipe_skid_reg.sv
// tb_dsp_pipe_skid_reg: directed and random checks of the skid register at WIDTH=18 and WIDTH=1.
// Stimulus pushes accepted beats into an expected-order queue; monitors pop on each output handshake.
// Reference is a plain FIFO of accepted beats, cleared by flush or reset.
module tb_dsp_pipe_skid_reg;

   localparam int W = 18;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic flush = 1'b0;
   logic s_valid = 1'b0;
   logic s_ready;
   logic [W-1:0] s_data = '0;
   logic m_valid;
   logic m_ready = 1'b0;
   logic [W-1:0] m_data;
   logic [1:0] count;

   logic rst1 = 1'b0;
   logic flush1 = 1'b0;
   logic s_valid1 = 1'b0;
   logic s_ready1;
   logic [0:0] s_data1 = '0;
   logic m_valid1;
   logic m_ready1 = 1'b0;
   logic [0:0] m_data1;
   logic [1:0] count1;

   int vectors = 0;
   int miscompares = 0;

   logic [W-1:0] q[$];
   int           pend = 0;
   logic         prev_stall = 1'b0;
   logic [W-1:0] prev_data = '0;

   logic [0:0]   q1[$];
   int           pend1 = 0;
   logic         prev_stall1 = 1'b0;
   logic [0:0]   prev_data1 = '0;
   logic         done1 = 1'b0;

   always #5 clk = ~clk;

   dsp_pipe_skid_reg #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .count(count)
   );

   dsp_pipe_skid_reg #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst1), .flush(flush1),
      .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
      .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1),
      .count(count1)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of stimulus; a beat the stage will accept goes into the expected queue.
   task automatic drive(input logic v, input logic [W-1:0] d, input logic mr, input logic fl);
      s_valid = v;
      s_data  = d;
      m_ready = mr;
      flush   = fl;
      pend    = (v && s_ready && !fl && !rst) ? 1 : 0;
      if (pend != 0) q.push_back(d);
      @(posedge clk);
      #1;
   endtask

   task automatic drive1(input logic v, input logic [0:0] d, input logic mr, input logic fl);
      s_valid1 = v;
      s_data1  = d;
      m_ready1 = mr;
      flush1   = fl;
      pend1    = (v && s_ready1 && !fl && !rst1) ? 1 : 0;
      if (pend1 != 0) q1.push_back(d);
      @(posedge clk);
      #1;
   endtask

   // Monitor for the WIDTH=18 instance, sampling mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         check("count_vs_model", 64'(count), 64'(q.size() - pend));
         check("s_ready_inv", 64'(s_ready), 64'(count != 2'd2));
         check("m_valid_inv", 64'(m_valid), 64'(count != 2'd0));
         if (prev_stall) check("stall_hold", 64'(m_data), 64'(prev_data));
         if (m_valid && m_ready) begin
            vectors++;
            if (q.size() == 0) begin
               miscompares++;
               $display("FAIL out_data: got 0x%0h, expected no beat (t=%0t)", m_data, $time);
            end else begin
               logic [W-1:0] e;
               e = q.pop_front();
               if (m_data !== e) begin
                  miscompares++;
                  $display("FAIL out_data: got 0x%0h, expected 0x%0h (t=%0t)", m_data, e, $time);
               end
            end
         end
         prev_stall = m_valid && !m_ready && !flush;
         prev_data  = m_data;
         if (flush) q.delete();
      end
   end

   // Monitor for the WIDTH=1 instance.
   always @(negedge clk) begin
      if (rst1) begin
         prev_stall1 = 1'b0;
      end else begin
         check("w1_count_vs_model", 64'(count1), 64'(q1.size() - pend1));
         check("w1_s_ready_inv", 64'(s_ready1), 64'(count1 != 2'd2));
         check("w1_m_valid_inv", 64'(m_valid1), 64'(count1 != 2'd0));
         if (prev_stall1) check("w1_stall_hold", 64'(m_data1), 64'(prev_data1));
         if (m_valid1 && m_ready1) begin
            vectors++;
            if (q1.size() == 0) begin
               miscompares++;
               $display("FAIL w1_out_data: got 0x%0h, expected no beat (t=%0t)", m_data1, $time);
            end else begin
               logic [0:0] e1;
               e1 = q1.pop_front();
               if (m_data1 !== e1) begin
                  miscompares++;
                  $display("FAIL w1_out_data: got 0x%0h, expected 0x%0h (t=%0t)", m_data1, e1, $time);
               end
            end
         end
         prev_stall1 = m_valid1 && !m_ready1 && !flush1;
         prev_data1  = m_data1;
         if (flush1) q1.delete();
      end
   end

   // Random traffic on the single-bit instance, in parallel with the main sequence.
   initial begin
      int acc1;
      int cyc1;
      #1 rst1 = 1'b1;
      #2 rst1 = 1'b0;
      @(posedge clk);
      #1;
      acc1 = 0;
      cyc1 = 0;
      while (acc1 < 2000 && cyc1 < 20000) begin
         drive1(1'($urandom_range(0, 1)), 1'($urandom), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 63) == 0));
         acc1 += pend1;
         cyc1++;
      end
      check("w1_rand_beats", 64'(acc1 >= 2000), 64'd1);
      for (int i = 0; i < 10 && q1.size() != 0; i++) drive1(1'b0, 1'b0, 1'b1, 1'b0);
      check("w1_drain_empty", 64'(q1.size()), 64'd0);
      done1 = 1'b1;
   end

   initial begin
      int acc;
      int cyc;
      int wt;

      // Reset state.
      #1 rst = 1'b1;
      #2;
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_s_ready", 64'(s_ready), 64'd1);
      check("rst_count", 64'(count), 64'd0);
      check("rst_m_data", 64'(m_data), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Fill to two, then reset mid-cycle: must clear without waiting for an edge.
      drive(1'b1, 18'h001, 1'b0, 1'b0);
      drive(1'b1, 18'h002, 1'b0, 1'b0);
      check("fill_count2", 64'(count), 64'd2);
      rst = 1'b1;
      q.delete();
      pend = 0;
      s_valid = 1'b1;
      s_data = 18'h155;
      #1;
      check("async_rst_m_valid", 64'(m_valid), 64'd0);
      check("async_rst_s_ready", 64'(s_ready), 64'd1);
      check("async_rst_count", 64'(count), 64'd0);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      rst = 1'b0;
      drive(1'b0, 18'h0, 1'b0, 1'b0);
      check("post_rst_m_valid", 64'(m_valid), 64'd0);
      drive(1'b1, 18'h00A, 1'b1, 1'b0);
      check("first_beat_data", 64'(m_data), 64'h00A);
      check("first_beat_valid", 64'(m_valid), 64'd1);
      drive(1'b0, 18'h0, 1'b1, 1'b0);

      // Streaming at full rate.
      for (int i = 1; i <= 20; i++) begin
         drive(1'b1, 18'(i), 1'b1, 1'b0);
         check("stream_data", 64'(m_data), 64'(i));
         check("stream_s_ready", 64'(s_ready), 64'd1);
         check("stream_count", 64'(count), 64'd1);
      end
      drive(1'b0, 18'h0, 1'b1, 1'b0);
      check("stream_drained", 64'(count), 64'd0);

      // Backpressure, then drain; also TWO->ONE and ONE with IN&OUT boundaries.
      drive(1'b1, 18'h111, 1'b0, 1'b0);
      drive(1'b1, 18'h222, 1'b0, 1'b0);
      check("bp_count", 64'(count), 64'd2);
      check("bp_s_ready", 64'(s_ready), 64'd0);
      check("bp_m_data", 64'(m_data), 64'h111);
      drive(1'b1, 18'h333, 1'b0, 1'b0);
      check("bp_hold_data", 64'(m_data), 64'h111);
      drive(1'b1, 18'h333, 1'b1, 1'b0);
      check("two_to_one_data", 64'(m_data), 64'h222);
      check("two_to_one_s_ready", 64'(s_ready), 64'd1);
      check("two_to_one_count", 64'(count), 64'd1);
      drive(1'b1, 18'h333, 1'b1, 1'b0);
      check("one_inout_data", 64'(m_data), 64'h333);
      check("one_inout_count", 64'(count), 64'd1);
      drive(1'b0, 18'h0, 1'b1, 1'b0);
      check("bp_drained", 64'(count), 64'd0);

      // Flush while full with a beat offered: the offered beat is dropped.
      drive(1'b1, 18'h100, 1'b0, 1'b0);
      drive(1'b1, 18'h200, 1'b0, 1'b0);
      drive(1'b1, 18'h3FF, 1'b0, 1'b1);
      check("flush_count", 64'(count), 64'd0);
      check("flush_m_valid", 64'(m_valid), 64'd0);
      check("flush_s_ready", 64'(s_ready), 64'd1);
      drive(1'b0, 18'h0, 1'b1, 1'b0);
      drive(1'b0, 18'h0, 1'b1, 1'b0);
      check("flush_stays_empty", 64'(m_valid), 64'd0);

      // Random traffic with occasional flush.
      acc = 0;
      cyc = 0;
      while (acc < 2000 && cyc < 20000) begin
         drive(1'($urandom_range(0, 1)), 18'($urandom), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 63) == 0));
         acc += pend;
         cyc++;
      end
      check("rand_beats", 64'(acc >= 2000), 64'd1);
      for (int i = 0; i < 10 && q.size() != 0; i++) drive(1'b0, 18'h0, 1'b1, 1'b0);
      check("drain_empty", 64'(q.size()), 64'd0);

      wt = 0;
      while (!done1 && wt < 30000) begin
         @(posedge clk);
         wt++;
      end
      check("w1_finished", 64'(done1), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
